// File: rtl/instruction_decode_stage.sv
// Decode stage: register file (32 x XLEN, x0 = 0), immediate generation, main control.
// Latency: decode/immediate/read outputs combinational; register writes commit on rising clk.
// Backpressure: none -- one instruction decoded per cycle, no stall or flush inputs.
// Ports: clk, rst (async active-low); pc/instruction from fetch; wb_en/wb_rd/wb_data
//   write-back port; rs1_data/rs2_data/imm/branch_offset operand outputs; rd/funct3/funct7_b5
//   fields; branch/mem_read/mem_to_reg/mem_write/alu_src/reg_write/alu_op/illegal control; pc_out.
module instruction_decode_stage #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     pc,
  input  logic [31:0]     instruction,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] branch_offset,
  output logic [4:0]      rd,
  output logic [2:0]      funct3,
  output logic            funct7_b5,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic            illegal,
  output logic [31:0]     pc_out
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic [XLEN-1:0] regs [NREGS];
  logic [6:0]      opcode;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            wb_hit;

  assign opcode    = instruction[6:0];
  assign rs1       = instruction[19:15];
  assign rs2       = instruction[24:20];
  assign rd        = instruction[11:7];
  assign funct3    = instruction[14:12];
  assign funct7_b5 = instruction[30];
  assign pc_out    = pc;

  // x0 is never written, so regs[0] stays zero from reset onward.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Write-first bypass; suppressed in reset because the write port is ignored then.
  assign wb_hit = rst && wb_en && (wb_rd != 5'd0);

  always_comb begin
    if (rs1 == 5'd0)                rs1_data = '0;
    else if (wb_hit && wb_rd == rs1) rs1_data = wb_data;
    else                             rs1_data = regs[rs1];
    if (rs2 == 5'd0)                rs2_data = '0;
    else if (wb_hit && wb_rd == rs2) rs2_data = wb_data;
    else                             rs2_data = regs[rs2];
  end

  // Immediate stays combinational even during reset.
  always_comb begin
    imm = '0;
    case (opcode)
      OP_IARITH, OP_LOAD:
        imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
      OP_STORE:
        imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:
        imm = {{(XLEN-13){instruction[31]}}, instruction[31], instruction[7],
               instruction[30:25], instruction[11:8], 1'b0};
      default: imm = '0;
    endcase
  end

  assign branch_offset = imm;

  always_comb begin
    branch     = 1'b0;
    mem_read   = 1'b0;
    mem_to_reg = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    if (rst) begin
      case (opcode)
        OP_R: begin
          reg_write = 1'b1;
          alu_op    = 2'b10;
        end
        OP_IARITH: begin
          reg_write = 1'b1;
          alu_src   = 1'b1;
          alu_op    = 2'b10;
        end
        OP_LOAD: begin
          reg_write  = 1'b1;
          alu_src    = 1'b1;
          mem_read   = 1'b1;
          mem_to_reg = 1'b1;
        end
        OP_STORE: begin
          mem_write = 1'b1;
          alu_src   = 1'b1;
        end
        OP_BRANCH: begin
          branch = 1'b1;
          alu_op = 2'b01;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/instruction_decode_stage.md
# instruction_decode_stage

Single-cycle decode stage that consumes the `pc`/`instruction` pair from the fetch stage. It holds the 32 x 64-bit integer register file and generates the sign-extended immediate and the main control signals. It also returns `branch` and `branch_offset` to fetch. Register writes arrive from the write-back path and commit on the rising clock edge.

## Interface
- `XLEN`, 64, register and immediate width
- `NREGS`, 32, architectural registers (x0 hardwired to zero)
- `clk`  in  1  system clock; all register-file writes on rising edge
- `rst`  in  1  asynchronous, active-low reset (clears register file, forces control outputs low)
- `pc`  in  32  address of current instruction (from fetch)
- `instruction`  in  32  instruction word (from fetch)
- `wb_en`  in  1  write-back enable
- `wb_rd`  in  5  write-back destination register
- `wb_data`  in  XLEN  write-back value
- `rs1_data`, `rs2_data`  out  XLEN  source operand values
- `imm`  out  XLEN  sign-extended immediate
- `branch_offset`  out  XLEN  equals `imm` (B-type byte offset), fed to fetch
- `rd`  out  5  destination field `instruction[11:7]`
- `funct3`  out  3  `instruction[14:12]`
- `funct7_b5`  out  1  `instruction[30]`
- `branch`, `mem_read`, `mem_to_reg`, `mem_write`, `alu_src`, `reg_write`  out  1 each  control
- `alu_op`  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- `illegal`  out  1  opcode not in supported set
- `pc_out`  out  32  `pc` passed through unchanged

## Operation
- Opcode `instruction[6:0]` decode:
  - R 0110011: reg_write=1, alu_op=10. All other controls 0.
  - I-arith 0010011: reg_write=1, alu_src=1, alu_op=10.
  - Load 0000011: reg_write=1, alu_src=1, mem_read=1, mem_to_reg=1, alu_op=00.
  - Store 0100011: mem_write=1, alu_src=1, alu_op=00.
  - Branch 1100011: branch=1, alu_op=01.
  - Any other opcode: all controls 0, `illegal`=1.
- Immediate:
  - I-type (load, I-arith): sext(`instr[31:20]`).
  - S-type: sext({`instr[31:25]`,`instr[11:7]`}).
  - B-type: sext({`instr[31]`,`instr[7]`,`instr[30:25]`,`instr[11:8]`,1'b0}).
  - R-type/illegal: 0.
  - Sign extension always from `instr[31]` to XLEN.
- Register file read ports:
  - `rs1` = `instr[19:15]`, `rs2` = `instr[24:20]`, both asynchronous reads.
  - Reading x0 returns 0 regardless of any write.
- Write port:
  - On rising `clk` with `rst`=1, `wb_en`=1 and `wb_rd`!=0: reg[`wb_rd`] <= `wb_data`.
  - Writes to x0 are discarded.
- Internal bypass: if `wb_en`=1, `wb_rd`!=0 and `wb_rd`==rs1 (or rs2), that read port returns `wb_data` in the same cycle (write-first).
- Reset (`rst`=0):
  - All 32 registers clear to 0 asynchronously.
  - All control outputs and `illegal` are forced to 0.
  - Write port ignored.
  - `imm`, field and `pc_out` outputs remain combinational.

## Timing
- Decode, immediate and read outputs are combinational from `instruction`/`pc`, with zero-cycle latency; fetch samples `branch`/`branch_offset` in the same cycle.
- A register write becomes architecturally visible at the rising edge. Via bypass it is visible in the cycle it is presented.
- Simultaneous `wb_rd`==rs1==rs2: both ports bypass.
- Reset assertion mid-cycle clears state immediately, without waiting for an edge. The first write after deassertion is honoured on the first rising edge with `rst`=1.
- No stall or flush inputs; one instruction decoded per cycle.

## Test plan
- Reset: hold `rst`=0, pulse clk with `wb_en`=1, `wb_rd`=5, `wb_data`=0xAA → all controls 0; after release, reading x5 returns 0.
- Write/read: write x3=0x1234 at edge, then `instruction`=0x003100B3 (add x1,x2,x3) → rs2_data=0x1234, reg_write=1, alu_op=10, rd=1.
- x0 protection: `wb_rd`=0, `wb_data`=0xFFFF, then read rs1=x0 → 0, including during the write cycle (no bypass).
- Bypass: x7 holds 5; present `wb_en`=1, `wb_rd`=7, `wb_data`=9 with an instruction reading rs1=rs2=x7 → both read 9 in the same cycle.
- Immediates:
  - ld x1,-8(x2) (0xFF813083) → imm=0xFFFF_FFFF_FFFF_FFF8, mem_read=1, mem_to_reg=1.
  - beq x1,x2,-4 (0xFE208EE3) → imm=branch_offset=-4, branch=1, alu_op=01.
  - sd x5,16(x2) (0x00513823) → imm=16, mem_write=1.
- Illegal: `instruction`=0x0000007F → `illegal`=1, all controls 0, `imm`=0.
